// File: rtl/compound_responder.sv
// Responder for CompoundType read/write transactions: two 32-bit slots,
// sequence-numbered record_t responses after a fixed EXEC latency.
module compound_responder #(
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] SEQ_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [31:0] req_x,
  input  logic        req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_x,
  output logic [31:0] rsp_y
);

  localparam int unsigned DATA_W = 32;
  localparam logic [3:0]  LAT    = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic                      mode_p0;
  logic signed [DATA_W-1:0]  x_p0;
  logic                      y_p0;
  logic signed [DATA_W-1:0]  slots [2];
  logic [31:0]               seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_p0   <= 1'b0;
      x_p0      <= '0;
      y_p0      <= 1'b0;
      slots[0]  <= '0;
      slots[1]  <= '0;
      seq       <= SEQ_INIT;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_x     <= '0;
      rsp_y     <= '0;
    end else begin
      case (state)
        // Request capture: p0 registers hold the accepted transaction
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mode_p0   <= req_mode;
            x_p0      <= req_x;
            y_p0      <= req_y;
            if (LATENCY > 0) begin
              state <= EXEC;
              cnt   <= LAT;
            end else begin
              state <= RESP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        // Latency stage: occupies exactly LATENCY cycles
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        // Response stage: first cycle loads the record, then waits for rsp_ready
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_y     <= seq;
            seq       <= seq + 32'd1;
            if (mode_p0) begin
              slots[y_p0] <= x_p0;
              rsp_x       <= x_p0;
            end else begin
              rsp_x <= slots[y_p0];
            end
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compound_responder.sv
// Bench for compound_responder: one instance with LATENCY=2/SEQ_INIT=0 and one
// with LATENCY=0/SEQ_INIT=0xFFFFFFFF, checked against a slot/sequence model.
module tb_compound_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_mode = 1'b0;
  logic [31:0] req_x = '0;
  logic        req_y = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        sel = 1'b0;

  logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
  logic [31:0] a_rsp_x, a_rsp_y, b_rsp_x, b_rsp_y;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_x, rsp_y;

  int errors = 0;
  int checks = 0;

  logic [31:0] slots_m [2];
  logic [31:0] seq_m;

  always #5 clk = ~clk;

  compound_responder #(.LATENCY(2), .SEQ_INIT(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_mode(req_mode), .req_x(req_x), .req_y(req_y), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_x(a_rsp_x), .rsp_y(a_rsp_y)
  );

  compound_responder #(.LATENCY(0), .SEQ_INIT(32'hFFFF_FFFF)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_mode(req_mode), .req_x(req_x), .req_y(req_y), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_x(b_rsp_x), .rsp_y(b_rsp_y)
  );

  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_x     = sel ? b_rsp_x     : a_rsp_x;
  assign rsp_y     = sel ? b_rsp_y     : a_rsp_y;

  function automatic int lat_m();
    return sel ? 0 : 2;
  endfunction

  task automatic model_reset();
    slots_m[0] = '0;
    slots_m[1] = '0;
    seq_m      = sel ? 32'hFFFF_FFFF : 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rsp_valid=%b req_ready=%b required 0 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_x !== 32'h0 || rsp_y !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b x=%h y=%h required 0 0 0 0",
               rsp_valid, req_ready, rsp_x, rsp_y);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  // One complete transaction; hold = cycles of rsp_ready=0 after rsp_valid rises
  task automatic txn(input logic mode, input logic [31:0] x, input logic y,
                     input int hold, input logic pulse);
    logic [31:0] ex, ey;
    int n;
    ex = mode ? x : slots_m[y];
    ey = seq_m;
    if (mode) slots_m[y] = x;
    seq_m = seq_m + 32'd1;

    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_mode  = mode;
    req_x     = x;
    req_y     = y;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mode  = 1'($urandom_range(0, 1));
    req_x     = $urandom;
    req_y     = 1'($urandom_range(0, 1));

    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != lat_m() + 1) begin
      errors++;
      $display("FAIL latency: cycles=%0d required %0d", n, lat_m() + 1);
    end
    checks++;
    if (rsp_x !== ex) begin
      errors++;
      $display("FAIL rsp_x: got %h required %h", rsp_x, ex);
    end
    checks++;
    if (rsp_y !== ey) begin
      errors++;
      $display("FAIL rsp_y: got %h required %h", rsp_y, ey);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_resp: req_ready=%b required 0", req_ready);
    end

    for (int i = 0; i < hold; i++) begin
      req_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_x !== ex || rsp_y !== ey || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%b x=%h y=%h ready=%b required 1 %h %h 0",
                 rsp_valid, rsp_x, rsp_y, req_ready, ex, ey);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;

    if (hold > 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    checks++;
    if (rsp_x !== ex || rsp_y !== ey) begin
      errors++;
      $display("FAIL post_handshake_hold: x=%h y=%h required %h %h", rsp_x, rsp_y, ex, ey);
    end
  endtask

  task automatic test_basic();
    txn(1'b1, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    txn(1'b0, 32'h0, 1'b1, 0, 1'b0);
    txn(1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    txn(1'b1, 32'hFFFF_FFFB, 1'b0, 10, 1'b1);
    txn(1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1;
    req_mode  = 1'b1;
    req_x     = 32'h1234_5678;
    req_y     = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: rsp_valid=%b req_ready=%b required 0 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: req_ready=%b required 1", req_ready);
    end
    txn(1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_dependence();
    test_reset();
    txn(1'b1, 32'h1, 1'b0, 0, 1'b0);
    txn(1'b1, 32'h2, 1'b1, 0, 1'b0);
    txn(1'b0, 32'h0, 1'b0, 0, 1'b0);
    txn(1'b0, 32'h0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random(input int count);
    for (int i = 0; i < count; i++) begin
      txn(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  task automatic test_wrap_zero_latency();
    sel = 1'b1;
    test_reset();
    txn(1'b0, 32'h0, 1'b0, 0, 1'b0);
    txn(1'b0, 32'h0, 1'b1, 0, 1'b0);
    test_random(10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_dependence();
    test_random(20);
    test_wrap_zero_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
